// File: rtl/div_arbiter.sv
// Three-requester round-robin front end for a shared iterative divider.
// Handles zero-divisor short-circuit, RUN timeout and registered result/ack fan-out.
module div_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                      clk_div,
    input  logic                      reset,
    input  logic [2:0]                req,
    input  logic [3*DATA_WIDTH-1:0]   req_dividend,
    input  logic [3*DATA_WIDTH-1:0]   req_divisor,
    output logic [2:0]                ack,
    output logic [2:0]                err,
    output logic [DATA_WIDTH-1:0]     res_quotient,
    output logic [DATA_WIDTH-1:0]     res_remainder,
    output logic                      busy,
    output logic                      div_reset,
    output logic                      div_start,
    output logic [DATA_WIDTH-1:0]     div_dividend,
    output logic [DATA_WIDTH-1:0]     div_divisor,
    input  logic [DATA_WIDTH-1:0]     div_quotient,
    input  logic [DATA_WIDTH-1:0]     div_remainder,
    input  logic                      div_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            ack_q, ack_d;
    logic [2:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] quo_q, quo_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] opa_q, opa_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d;
    logic                  busy_q, busy_d;
    logic                  div_reset_q, div_reset_d;
    logic                  div_start_q, div_start_d;

    logic                  found;
    logic [1:0]            sel;
    int unsigned           idx;
    logic [DATA_WIDTH-1:0] sel_dividend;
    logic [DATA_WIDTH-1:0] sel_divisor;

    // Round-robin search starting at rr_ptr_q; the latched operand registers double as div_* outputs.
    always_comb begin
        found        = 1'b0;
        sel          = rr_ptr_q;
        idx          = 0;
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = (32'(rr_ptr_q) + k) % 3;
            if (!found && req[idx]) begin
                found        = 1'b1;
                sel          = 2'(idx);
                sel_dividend = req_dividend[idx*DATA_WIDTH +: DATA_WIDTH];
                sel_divisor  = req_divisor[idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        err_d    = '0;
        quo_d    = quo_q;
        rem_d    = rem_q;
        opa_d    = opa_q;
        opb_d    = opb_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = sel;
                    rr_ptr_d = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
                    opa_d    = sel_dividend;
                    opb_d    = sel_divisor;
                    if (sel_divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = sel_dividend;
                        ack_d   = 3'b001 << sel;
                        err_d   = 3'b001 << sel;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (div_done) begin
                    state_d = DONE;
                    quo_d   = div_quotient;
                    rem_d   = div_remainder;
                    ack_d   = 3'b001 << grant_q;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = '0;
                    ack_d   = 3'b001 << grant_q;
                    err_d   = 3'b001 << grant_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        div_start_d = (state_d == LOAD) || (state_d == RUN);
        div_reset_d = (state_d != RUN);
    end

    always_ff @(posedge clk_div) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            err_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            busy_q      <= 1'b0;
            div_reset_q <= 1'b1;
            div_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            busy_q      <= busy_d;
            div_reset_q <= div_reset_d;
            div_start_q <= div_start_d;
        end
    end

    assign ack           = ack_q;
    assign err           = err_q;
    assign res_quotient  = quo_q;
    assign res_remainder = rem_q;
    assign busy          = busy_q;
    assign div_reset     = div_reset_q;
    assign div_start     = div_start_q;
    assign div_dividend  = opa_q;
    assign div_divisor   = opb_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: directed scenarios plus randomized jobs
// against an arithmetic round-robin/divide reference model and a latency-programmable divider model.
module tb_div_arbiter;

    localparam int DW = 32;
    localparam int TO = 64;

    logic            clk_div = 1'b0;
    logic            reset;
    logic [2:0]      req;
    logic [3*DW-1:0] req_dividend;
    logic [3*DW-1:0] req_divisor;
    logic [2:0]      ack;
    logic [2:0]      err;
    logic [DW-1:0]   res_quotient;
    logic [DW-1:0]   res_remainder;
    logic            busy;
    logic            div_reset;
    logic            div_start;
    logic [DW-1:0]   div_dividend;
    logic [DW-1:0]   div_divisor;
    logic [DW-1:0]   div_quotient;
    logic [DW-1:0]   div_remainder;
    logic            div_done;

    int checks = 0;
    int errors = 0;
    int last_grant = 2;
    int start_seen = 0;

    int m_cnt = 0;
    int m_lat = 10;
    bit m_enable = 1'b1;

    always #5 clk_div = ~clk_div;

    div_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_div       (clk_div),
        .reset         (reset),
        .req           (req),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .ack           (ack),
        .err           (err),
        .res_quotient  (res_quotient),
        .res_remainder (res_remainder),
        .busy          (busy),
        .div_reset     (div_reset),
        .div_start     (div_start),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .div_done      (div_done)
    );

    // Divider model: counts started, non-reset cycles and raises done after m_lat of them.
    always @(posedge clk_div) begin
        if (div_reset) begin
            m_cnt    <= 0;
            div_done <= 1'b0;
        end else if (div_start && !div_done && m_enable) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 >= m_lat) begin
                div_done      <= 1'b1;
                div_quotient  <= (div_divisor != 0) ? div_dividend / div_divisor : '1;
                div_remainder <= (div_divisor != 0) ? div_dividend % div_divisor : '0;
            end
        end
    end

    always @(posedge clk_div) begin
        if (div_start) start_seen = start_seen + 1;
    end

    function automatic int rr_pick(input int last, input logic [2:0] mask);
        for (int k = 1; k <= 3; k++) begin
            if (mask[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_dividend[i*DW +: DW] = a;
        req_divisor[i*DW +: DW]  = b;
    endtask

    task automatic wait_ack(input int maxc, output logic [2:0] a, output logic [2:0] e, output int cyc);
        a = '0;
        e = '0;
        cyc = 0;
        while (cyc < maxc) begin
            @(negedge clk_div);
            cyc++;
            if (ack !== 3'b000) begin
                a = ack;
                e = err;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req = '0;
        req_dividend = '0;
        req_divisor = '0;
        repeat (3) @(negedge clk_div);
        checks++; if (ack !== 3'b000)    begin errors++; $display("FAIL reset_ack got %b want 000", ack); end
        checks++; if (err !== 3'b000)    begin errors++; $display("FAIL reset_err got %b want 000", err); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got %b want 0", div_start); end
        checks++; if (div_reset !== 1'b1) begin errors++; $display("FAIL reset_div_reset got %b want 1", div_reset); end
        checks++; if (res_quotient !== '0 || res_remainder !== '0)
            begin errors++; $display("FAIL reset_res got %0h/%0h want 0/0", res_quotient, res_remainder); end
        checks++; if (div_dividend !== '0 || div_divisor !== '0)
            begin errors++; $display("FAIL reset_ops got %0h/%0h want 0/0", div_dividend, div_divisor); end
        reset = 1'b0;
        last_grant = 2;
        @(negedge clk_div);
    endtask

    task automatic test_contention;
        logic [2:0] a, e;
        logic [2:0] exp_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        int cyc;
        m_enable = 1'b1;
        m_lat = 4;
        for (int i = 0; i < 3; i++) set_ops(i, 10, 3);
        req = 3'b111;
        for (int j = 0; j < 4; j++) begin
            wait_ack(200, a, e, cyc);
            if (j == 3) req = '0;
            checks++; if (a !== exp_order[j]) begin errors++; $display("FAIL contention_ack%0d got %b want %b", j, a, exp_order[j]); end
            checks++; if (e !== 3'b000) begin errors++; $display("FAIL contention_err%0d got %b want 000", j, e); end
            checks++; if (res_quotient !== 3 || res_remainder !== 1)
                begin errors++; $display("FAIL contention_res%0d got %0d/%0d want 3/1", j, res_quotient, res_remainder); end
            last_grant = rr_pick(last_grant, 3'b111);
        end
        repeat (2) @(negedge clk_div);
    endtask

    task automatic test_single;
        logic [2:0] a, e;
        int cyc;
        m_lat = 33;
        set_ops(0, 450, 100);
        req = 3'b001;
        wait_ack(200, a, e, cyc);
        req = '0;
        last_grant = 0;
        checks++; if (a !== 3'b001) begin errors++; $display("FAIL single_ack got %b want 001", a); end
        checks++; if (e !== 3'b000) begin errors++; $display("FAIL single_err got %b want 000", e); end
        checks++; if (res_quotient !== 4 || res_remainder !== 50)
            begin errors++; $display("FAIL single_res got %0d/%0d want 4/50", res_quotient, res_remainder); end
        checks++; if (cyc < 36) begin errors++; $display("FAIL single_latency got %0d cycles want >= 36", cyc); end
        @(negedge clk_div);
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL single_ack_pulse got %b want 000", ack); end
        checks++; if (res_quotient !== 4 || res_remainder !== 50)
            begin errors++; $display("FAIL single_res_hold got %0d/%0d want 4/50", res_quotient, res_remainder); end
        @(negedge clk_div);
    endtask

    task automatic test_zero_div;
        logic [2:0] a, e;
        int cyc;
        start_seen = 0;
        set_ops(1, 77, 0);
        req = 3'b010;
        wait_ack(20, a, e, cyc);
        req = '0;
        last_grant = 1;
        checks++; if (a !== 3'b010 || e !== 3'b010) begin errors++; $display("FAIL zero_ack_err got %b/%b want 010/010", a, e); end
        checks++; if (cyc > 2) begin errors++; $display("FAIL zero_latency got %0d cycles want <= 2", cyc); end
        checks++; if (res_quotient !== 32'hFFFFFFFF || res_remainder !== 77)
            begin errors++; $display("FAIL zero_res got %0h/%0d want ffffffff/77", res_quotient, res_remainder); end
        repeat (2) @(negedge clk_div);
        checks++; if (start_seen !== 0) begin errors++; $display("FAIL zero_div_start got %0d pulses want 0", start_seen); end
    endtask

    task automatic test_timeout;
        int run_cycles = 0;
        int cyc = 0;
        logic [2:0] a = '0, e = '0;
        m_enable = 1'b0;
        set_ops(2, 1234, 5);
        req = 3'b100;
        while (cyc < 200 && a === 3'b000) begin
            @(negedge clk_div);
            cyc++;
            if (cyc == 2) req = '0;
            if (div_start && !div_reset) run_cycles++;
            if (ack !== 3'b000) begin a = ack; e = err; end
        end
        last_grant = 2;
        checks++; if (a !== 3'b100 || e !== 3'b100) begin errors++; $display("FAIL timeout_ack_err got %b/%b want 100/100", a, e); end
        checks++; if (run_cycles !== TO) begin errors++; $display("FAIL timeout_run_cycles got %0d want %0d", run_cycles, TO); end
        checks++; if (res_quotient !== 32'hFFFFFFFF || res_remainder !== 0)
            begin errors++; $display("FAIL timeout_res got %0h/%0d want ffffffff/0", res_quotient, res_remainder); end
        @(negedge clk_div);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
        m_enable = 1'b1;
    endtask

    task automatic test_timeout_boundary;
        logic [2:0] a, e;
        int cyc;
        m_lat = TO - 1;
        set_ops(0, 100, 9);
        req = 3'b001;
        wait_ack(200, a, e, cyc);
        req = '0;
        last_grant = 0;
        checks++; if (a !== 3'b001 || e !== 3'b000) begin errors++; $display("FAIL edge_ok_ack_err got %b/%b want 001/000", a, e); end
        checks++; if (res_quotient !== 11 || res_remainder !== 1)
            begin errors++; $display("FAIL edge_ok_res got %0d/%0d want 11/1", res_quotient, res_remainder); end
        @(negedge clk_div);
        m_lat = TO;
        set_ops(1, 100, 9);
        req = 3'b010;
        wait_ack(200, a, e, cyc);
        req = '0;
        last_grant = 1;
        checks++; if (a !== 3'b010 || e !== 3'b010) begin errors++; $display("FAIL edge_to_ack_err got %b/%b want 010/010", a, e); end
        checks++; if (res_quotient !== 32'hFFFFFFFF || res_remainder !== 0)
            begin errors++; $display("FAIL edge_to_res got %0h/%0d want ffffffff/0", res_quotient, res_remainder); end
        @(negedge clk_div);
    endtask

    task automatic test_operand_change;
        logic [2:0] a, e;
        int cyc = 0;
        m_lat = 12;
        set_ops(2, 1000, 7);
        req = 3'b100;
        while (cyc < 20 && !(div_start && !div_reset)) begin @(negedge clk_div); cyc++; end
        set_ops(2, 5, 1);
        wait_ack(100, a, e, cyc);
        req = '0;
        last_grant = 2;
        checks++; if (a !== 3'b100 || e !== 3'b000) begin errors++; $display("FAIL opchg_ack_err got %b/%b want 100/000", a, e); end
        checks++; if (res_quotient !== 142 || res_remainder !== 6)
            begin errors++; $display("FAIL opchg_res got %0d/%0d want 142/6", res_quotient, res_remainder); end
        @(negedge clk_div);
    endtask

    task automatic test_reset_mid_run;
        logic [2:0] a, e;
        logic [2:0] ack_during = '0;
        int cyc = 0;
        m_lat = 40;
        set_ops(0, 900, 30);
        req = 3'b001;
        while (cyc < 20 && !(div_start && !div_reset)) begin @(negedge clk_div); cyc++; end
        req = '0;
        repeat (5) begin @(negedge clk_div); ack_during |= ack; end
        reset = 1'b1;
        repeat (2) begin @(negedge clk_div); ack_during |= ack; end
        checks++; if (ack_during !== 3'b000 || err !== 3'b000)
            begin errors++; $display("FAIL midrun_no_ack got %b/%b want 000/000", ack_during, err); end
        checks++; if (div_reset !== 1'b1 || busy !== 1'b0 || div_start !== 1'b0)
            begin errors++; $display("FAIL midrun_outputs got rst=%b busy=%b start=%b want 1/0/0", div_reset, busy, div_start); end
        reset = 1'b0;
        last_grant = 2;
        @(negedge clk_div);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_idle_after got busy=%b want 0", busy); end
        m_lat = 7;
        set_ops(1, 81, 4);
        req = 3'b010;
        wait_ack(100, a, e, cyc);
        req = '0;
        last_grant = 1;
        checks++; if (a !== 3'b010 || e !== 3'b000) begin errors++; $display("FAIL midrun_next_ack got %b/%b want 010/000", a, e); end
        checks++; if (res_quotient !== 20 || res_remainder !== 1)
            begin errors++; $display("FAIL midrun_next_res got %0d/%0d want 20/1", res_quotient, res_remainder); end
        @(negedge clk_div);
    endtask

    task automatic test_random;
        logic [2:0] mask, a, e, exp_ack;
        logic [DW-1:0] opa [3];
        logic [DW-1:0] opb [3];
        logic [DW-1:0] exp_q, exp_r;
        int w, cyc, lat;
        for (int n = 0; n < 30; n++) begin
            mask = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                opa[i] = $urandom;
                opb[i] = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom_range(1, 5000));
                set_ops(i, opa[i], opb[i]);
            end
            lat = ($urandom_range(0, 6) == 0) ? 80 : $urandom_range(1, 20);
            m_lat = lat;
            w = rr_pick(last_grant, mask);
            exp_ack = 3'b001 << w;
            if (opb[w] == 0) begin
                exp_q = '1; exp_r = opa[w];
            end else if (lat >= TO) begin
                exp_q = '1; exp_r = '0;
            end else begin
                exp_q = opa[w] / opb[w]; exp_r = opa[w] % opb[w];
            end
            req = mask;
            wait_ack(200, a, e, cyc);
            req = '0;
            last_grant = w;
            checks++; if (a !== exp_ack) begin errors++; $display("FAIL rand%0d_ack got %b want %b", n, a, exp_ack); end
            checks++; if (e !== ((opb[w] == 0 || lat >= TO) ? exp_ack : 3'b000))
                begin errors++; $display("FAIL rand%0d_err got %b", n, e); end
            checks++; if (res_quotient !== exp_q || res_remainder !== exp_r)
                begin errors++; $display("FAIL rand%0d_res got %0h/%0h want %0h/%0h", n, res_quotient, res_remainder, exp_q, exp_r); end
            @(negedge clk_div);
            checks++; if (ack !== 3'b000) begin errors++; $display("FAIL rand%0d_ack_pulse got %b want 000", n, ack); end
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_dividend = '0;
        req_divisor = '0;
        @(negedge clk_div);
        test_reset();
        test_contention();
        test_single();
        test_zero_div();
        test_timeout();
        test_operand_change();
        test_timeout_boundary();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1);
    end

endmodule
